// File: rtl/lc3b_line_mem.sv
// Line-granular memory responder for the LC-3b pmem interface: fixed-latency read/writeback of 128-bit lines.
// Optional per-byte write mask enabled by defining LC3B_LINE_MEM_WMASK_EN.
module lc3b_line_mem #(
   parameter int unsigned INDEX_W = 8,
   parameter int unsigned LATENCY = 4
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           pmem_read,
   input  logic           pmem_write,
   input  logic [15:0]    pmem_address,
   input  logic [127:0]   pmem_wdata,
`ifdef LC3B_LINE_MEM_WMASK_EN
   input  logic [15:0]    pmem_wmask,
`endif
   output logic [127:0]   pmem_rdata,
   output logic           pmem_resp,
   output logic           pmem_error
);

   localparam int unsigned LINE_W = 128;
   localparam int unsigned BYTES  = LINE_W / 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DEPTH  = 2 ** INDEX_W;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 op_write_q, op_write_d;
   logic [INDEX_W-1:0]   idx_q, idx_d;
   logic [LINE_W-1:0]    wdata_q, wdata_d;
   logic [BYTES-1:0]     wmask_q, wmask_d;
   logic [LINE_W-1:0]    rdata_q, rdata_d;
   logic                 resp_q, resp_d;
   logic                 error_q, error_d;

   logic [LINE_W-1:0]    mem [DEPTH];

   logic                 enter_resp_c;
   logic                 cur_write_c;
   logic [INDEX_W-1:0]   cur_idx_c;
   logic [LINE_W-1:0]    cur_wdata_c;
   logic [BYTES-1:0]     cur_wmask_c;
   logic [LINE_W-1:0]    mem_wline_c;
   logic                 mem_we_c;
   logic [BYTES-1:0]     in_wmask_c;
   logic                 unused_addr_c;

`ifdef LC3B_LINE_MEM_WMASK_EN
   assign in_wmask_c = pmem_wmask;
`else
   assign in_wmask_c = {BYTES{1'b1}};
`endif

   // Offset and tag bits do not select storage.
   assign unused_addr_c = ^pmem_address;

   // With LATENCY==1 the commit happens on the accepting edge, so use live inputs while IDLE.
   always_comb begin
      cur_write_c = op_write_q;
      cur_idx_c   = idx_q;
      cur_wdata_c = wdata_q;
      cur_wmask_c = wmask_q;
      if (state_q == S_IDLE) begin
         cur_write_c = pmem_write;
         cur_idx_c   = pmem_address[INDEX_W+3:4];
         cur_wdata_c = pmem_wdata;
         cur_wmask_c = in_wmask_c;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      op_write_d   = op_write_q;
      idx_d        = idx_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      rdata_d      = rdata_q;
      error_d      = error_q;
      enter_resp_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pmem_read || pmem_write) begin
               op_write_d = pmem_write;
               idx_d      = pmem_address[INDEX_W+3:4];
               wdata_d    = pmem_wdata;
               wmask_d    = in_wmask_c;
               cnt_d      = CNT_W'(LATENCY - 1);
               error_d    = error_q | (pmem_read & pmem_write);
               if (LATENCY > 1) begin
                  state_d = S_BUSY;
               end else begin
                  state_d      = S_RESP;
                  enter_resp_c = 1'b1;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d      = S_RESP;
               enter_resp_c = 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      resp_d = enter_resp_c;
      if (enter_resp_c && !cur_write_c) begin
         rdata_d = mem[cur_idx_c];
      end
   end

   // Byte-merge the write line with the stored line.
   always_comb begin
      mem_we_c    = enter_resp_c & cur_write_c;
      mem_wline_c = mem[cur_idx_c];
      for (int i = 0; i < int'(BYTES); i++) begin
         if (cur_wmask_c[i]) begin
            mem_wline_c[8*i +: 8] = cur_wdata_c[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_write_q <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         wmask_q    <= '0;
         rdata_q    <= '0;
         resp_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_write_q <= op_write_d;
         idx_q      <= idx_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         rdata_q    <= rdata_d;
         resp_q     <= resp_d;
         error_q    <= error_d;
      end
   end

   // Line array is not reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && mem_we_c) begin
         mem[cur_idx_c] <= mem_wline_c;
      end
   end

   assign pmem_rdata = rdata_q;
   assign pmem_resp  = resp_q;
   assign pmem_error = error_q;

endmodule

// File: tb/tb_lc3b_line_mem.sv
// Directed bench for lc3b_line_mem: one instance at LATENCY=4, one at LATENCY=1.
module tb_lc3b_line_mem;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rd4 = 1'b0, wr4 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
   logic [15:0]  a4 = '0, a1 = '0;
   logic [127:0] wd4 = '0, wd1 = '0;
   logic [127:0] rdata4, rdata1;
   logic         resp4, resp1, err4, err1;
`ifdef LC3B_LINE_MEM_WMASK_EN
   logic [15:0]  wm4 = 16'hFFFF, wm1 = 16'hFFFF;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lc3b_line_mem #(.INDEX_W(8), .LATENCY(4)) u_dut4 (
      .clk(clk), .reset(reset), .pmem_read(rd4), .pmem_write(wr4),
      .pmem_address(a4), .pmem_wdata(wd4),
`ifdef LC3B_LINE_MEM_WMASK_EN
      .pmem_wmask(wm4),
`endif
      .pmem_rdata(rdata4), .pmem_resp(resp4), .pmem_error(err4));

   lc3b_line_mem #(.INDEX_W(8), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .pmem_read(rd1), .pmem_write(wr1),
      .pmem_address(a1), .pmem_wdata(wd1),
`ifdef LC3B_LINE_MEM_WMASK_EN
      .pmem_wmask(wm1),
`endif
      .pmem_rdata(rdata1), .pmem_resp(resp1), .pmem_error(err1));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; issues one request and waits for its response pulse.
   task automatic xact(input bit sel, input logic r, input logic w, input logic [15:0] a,
                       input logic [127:0] d, input int lat, input string tag, output int rcyc);
      int k;
      k = 0;
      if (sel) begin rd1 = r; wr1 = w; a1 = a; wd1 = d; end
      else     begin rd4 = r; wr4 = w; a4 = a; wd4 = d; end
      do begin
         @(posedge clk); #1;
         k++;
      end while (!(sel ? resp1 : resp4) && k < 40);
      rcyc = cyc;
      rd1 = 1'b0; wr1 = 1'b0; rd4 = 1'b0; wr4 = 1'b0;
      check({tag, "_lat"}, 128'(k), 128'(lat));
      @(posedge clk); #1;
      check({tag, "_pulse"}, {127'b0, (sel ? resp1 : resp4)}, 128'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   localparam logic [127:0] D_BEEF = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
   localparam logic [127:0] D_A1   = 128'hA1A1_0000_1111_2222_3333_4444_5555_A1A1;
   localparam logic [127:0] D_C3   = 128'hC3C3_C3C3_0123_4567_89AB_CDEF_C3C3_C3C3;
   localparam logic [127:0] D_BAD  = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
   localparam logic [127:0] D_E7   = 128'hE7E7_E7E7_FFFF_0000_E7E7_E7E7_1234_5678;
   localparam logic [127:0] D_11   = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
   localparam logic [127:0] D_22   = 128'h2222_2222_2222_2222_2222_2222_2222_2222;

   initial begin
      int rc, rc1, rc2, n;
      do_reset();
      check("rst_resp", {127'b0, resp4}, 128'd0);
      check("rst_rdata", rdata4, 128'd0);
      check("rst_err", {127'b0, err4}, 128'd0);

      // Write then read back idx 5; a write leaves rdata alone.
      xact(1'b0, 1'b0, 1'b1, 16'h0050, D_BEEF, 4, "wr5", rc);
      check("wr5_rdata_hold", rdata4, 128'd0);
      xact(1'b0, 1'b1, 1'b0, 16'h0050, '0, 4, "rd5", rc);
      check("rd5_data", rdata4, D_BEEF);

      // Aliasing: tag and offset bits ignored.
      xact(1'b0, 1'b0, 1'b1, 16'h0010, D_A1, 4, "wr_al", rc);
      xact(1'b0, 1'b1, 1'b0, 16'h1010, '0, 4, "rd_tag", rc);
      check("alias_tag", rdata4, D_A1);
      xact(1'b0, 1'b1, 1'b0, 16'h0050, '0, 4, "rd5b", rc);
      xact(1'b0, 1'b1, 1'b0, 16'h001F, '0, 4, "rd_off", rc);
      check("alias_off", rdata4, D_A1);

      // Reset aborts an in-flight write, both mid-BUSY and on the commit edge.
      xact(1'b0, 1'b0, 1'b1, 16'h0030, D_C3, 4, "wr3", rc);
      for (int dly = 1; dly <= 2; dly++) begin
         rd4 = 1'b0; wr4 = 1'b1; a4 = 16'h0030; wd4 = D_BAD;
         @(posedge clk); #1;
         repeat (dly) begin @(posedge clk); #1; end
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0; wr4 = 1'b0;
         n = 0;
         repeat (8) begin @(posedge clk); #1; if (resp4) n++; end
         check($sformatf("abort%0d_noresp", dly), 128'(n), 128'd0);
         xact(1'b0, 1'b1, 1'b0, 16'h0030, '0, 4, "rd3", rc);
         check($sformatf("abort%0d_data", dly), rdata4, D_C3);
      end

      // Read+write together: write wins, sticky error, rdata unchanged.
      check("pre_err", {127'b0, err4}, 128'd0);
      xact(1'b0, 1'b1, 1'b1, 16'h0070, D_E7, 4, "rw7", rc);
      check("rw7_err", {127'b0, err4}, 128'd1);
      check("rw7_rdata_hold", rdata4, D_C3);
      xact(1'b0, 1'b1, 1'b0, 16'h0070, '0, 4, "rd7", rc);
      check("rd7_data", rdata4, D_E7);
      check("err_sticky", {127'b0, err4}, 128'd1);
      do_reset();
      check("err_cleared", {127'b0, err4}, 128'd0);

`ifdef LC3B_LINE_MEM_WMASK_EN
      wm4 = 16'hFFFF;
      xact(1'b0, 1'b0, 1'b1, 16'h0000, {16{8'hAA}}, 4, "wm_fill", rc);
      wm4 = 16'h00F0;
      xact(1'b0, 1'b0, 1'b1, 16'h0000, {16{8'h55}}, 4, "wm_part", rc);
      wm4 = 16'h0000;
      xact(1'b0, 1'b0, 1'b1, 16'h0000, {16{8'h33}}, 4, "wm_none", rc);
      wm4 = 16'hFFFF;
      xact(1'b0, 1'b1, 1'b0, 16'h0000, '0, 4, "wm_rd", rc);
      check("wm_data", rdata4, 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_AAAA_AAAA);
`endif

      // LATENCY=1 back-to-back reads: responses two cycles apart.
      xact(1'b1, 1'b0, 1'b1, 16'h0010, D_11, 1, "l1_wr1", rc);
      xact(1'b1, 1'b0, 1'b1, 16'h0020, D_22, 1, "l1_wr2", rc);
      xact(1'b1, 1'b1, 1'b0, 16'h0010, '0, 1, "l1_rd1", rc1);
      check("l1_rd1_data", rdata1, D_11);
      xact(1'b1, 1'b1, 1'b0, 16'h0020, '0, 1, "l1_rd2", rc2);
      check("l1_rd2_data", rdata1, D_22);
      check("l1_spacing", 128'(rc2 - rc1), 128'd2);
      check("l1_err", {127'b0, err1}, 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
